ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard over the same open-drain clock/data pair that `keyboard_for_ace` receives on, such as LED updates (0xED), reset (0xFF) and typematic settings. It runs in the 6.5 MHz `clk65` domain and drives the bus only through active-high output-enable (pull-low) signals. During a transfer, `busy` tells the receiver to ignore bus activity.

---
 rtl/ps2_pkg.sv | 10 +
 rtl/ps2_line_sync.sv | 27 ++
 rtl/ps2_host_tx.sv | 100 ++++++++++
 tb/tb_ps2_host_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and constants for the PS/2 host transmitter.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, STOP, ACK, WAIT_IDLE, ERR} ps2_state_t;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [3:0] LAST_DATA    = 4'd9;
    localparam logic [3:0] STOP_FALL    = 4'd10;
    localparam logic [3:0] ACK_FALL     = 4'd11;
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 lines plus a registered clock falling-edge detector.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2clk_in,
    input  logic ps2data_in,
    output logic clk_s,
    output logic data_s,
    output logic fall
);
    logic [2:0] c;
    logic [1:0] d;
    // Idle bus level is high, so resetting to 1 avoids a spurious edge on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c    <= '1;
            d    <= '1;
            fall <= 1'b0;
        end else begin
            c    <= {c[1:0], ps2clk_in};
            d    <= {d[0], ps2data_in};
            fall <= c[2] & ~c[1];
        end
    end
    assign clk_s  = c[1];
    assign data_s = d[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter driving the open-drain bus through pull-low enables.
module ps2_host_tx #(
    parameter int CLKFREQ_KHZ = 6500,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_CYC = 97500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] tx_data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error
);
    import ps2_pkg::*;
    localparam int INHIBIT_CYC = CLKFREQ_KHZ * INHIBIT_US / 1000;
    ps2_state_t  state, state_n;
    logic [16:0] cnt, cnt_n;
    logic [3:0]  bits, bits_n;
    logic [8:0]  frame, frame_n;
    logic        done_n;
    logic        clk_s, data_s, fall;
    ps2_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .ps2clk_in (ps2clk_in),
        .ps2data_in(ps2data_in),
        .clk_s     (clk_s),
        .data_s    (data_s),
        .fall      (fall)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            frame <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bits  <= bits_n;
            frame <= frame_n;
            done  <= done_n;
        end
    end
    // cnt times the inhibit phase, then restarts at RTS entry as the saturating transfer timeout.
    always_comb begin
        state_n = state;
        cnt_n   = (cnt == '1) ? cnt : cnt + 17'd1;
        bits_n  = bits;
        frame_n = frame;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (send && !done) begin
                    state_n = INHIBIT;
                    frame_n = {~^tx_data, tx_data};
                end
            end
            INHIBIT: if (cnt == 17'(INHIBIT_CYC - 1)) begin
                state_n = RTS;
                cnt_n   = '0;
            end
            RTS: if (fall) begin
                state_n = DATA;
                bits_n  = 4'd1;
            end
            DATA: if (fall) begin
                bits_n  = bits + 4'd1;
                frame_n = {1'b1, frame[8:1]};
                state_n = (bits == LAST_DATA) ? STOP : DATA;
            end
            STOP: state_n = (bits == STOP_FALL) ? ACK : ERR;
            ACK: if (fall) begin
                bits_n  = ACK_FALL;
                state_n = data_s ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_s && data_s) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            ERR: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state inside {RTS, DATA, STOP, ACK, WAIT_IDLE} && cnt == 17'(TIMEOUT_CYC - 1)) begin
            state_n = ERR;
            done_n  = 1'b0;
        end
    end
    assign busy       = state != IDLE && state != ERR;
    assign error      = state == ERR;
    assign ps2clk_oe  = state == INHIBIT;
    assign ps2data_oe = state == RTS || (state == DATA && !frame[0]);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device and a frame-level reference model.
module tb_ps2_host_tx;
    import ps2_pkg::*;
    localparam int INH = 780;
    localparam int TO  = 9750;
    logic       clk = 0, reset = 0, send = 0, dev_clk = 1, dev_data = 1;
    logic [7:0] tx_data = '0;
    logic       ps2clk_oe, ps2data_oe, busy, done, error;
    logic       clk_line, data_line;
    int         checks = 0, failures = 0, done_cnt = 0, err_cnt = 0, half = 260;
    logic       prev_pulse = 0;
    assign clk_line  = ~ps2clk_oe & dev_clk;
    assign data_line = ~ps2data_oe & dev_data;
    always #5 clk = ~clk;
    ps2_host_tx #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2clk_in (clk_line),
        .ps2data_in(data_line),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe),
        .tx_data   (tx_data),
        .send      (send),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Device-observed frame: bit0..bit7, odd parity, stop bit 1.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones = $countones(b);
        return {1'b1, (ones % 2) == 0, b};
    endfunction
    always @(negedge clk) begin
        if (done || error) begin
            if (done) done_cnt++;
            if (error) err_cnt++;
            check("pulse_busy", busy, 0);
            check("pulse_oe", {ps2clk_oe, ps2data_oe}, 0);
            check("pulse_width", prev_pulse, 0);
        end
        prev_pulse = done | error;
    end
    task automatic start(input logic [7:0] b);
        int c = 0;
        @(negedge clk); tx_data = b; send = 1;
        @(negedge clk); send = 0; tx_data = 8'($urandom);
        check("busy_start", busy, 1);
        while (ps2clk_oe && c < 2000) begin c++; @(negedge clk); end
        check("inhibit_len", c, INH);
        check("rts_data_oe", ps2data_oe, 1);
    endtask
    // mode 0: normal, 1: stray sends mid-frame and in the done cycle, 2: reset after fall 5
    task automatic xfer(input logic [7:0] b, input bit nack, input int mode);
        logic [9:0] got = '0, fr = frame_of(b);
        int c = 0, d0 = done_cnt, e0 = err_cnt;
        bit aborted = 0;
        start(b);
        repeat (50) @(negedge clk);
        for (int i = 1; i <= 11 && !aborted; i++) begin
            if (i == 11) begin dev_data = nack; repeat (20) @(negedge clk); end
            dev_clk = 0;
            if (i == 5 && mode == 1) begin
                @(negedge clk); tx_data = 8'h55; send = 1;
                @(negedge clk); send = 0;
            end
            if (i == 5 && mode == 2) begin
                repeat (10) @(negedge clk);
                check("pre_reset_data_oe", ps2data_oe, !fr[4]);
                #1 reset = 0;
                #1 check("reset_oe", {ps2clk_oe, ps2data_oe}, 0);
                check("reset_busy", busy, 0);
                dev_clk = 1;
                @(negedge clk); reset = 1;
                aborted = 1;
            end else begin
                repeat (half) @(negedge clk);
                dev_clk = 1;
                if (i <= 10) got[i-1] = data_line;
                repeat (half) @(negedge clk);
            end
        end
        dev_data = 1;
        if (!aborted && !nack) begin
            while (!done && !error && c < 100) begin @(negedge clk); c++; end
            if (mode == 1 && done) begin
                tx_data = 8'h55; send = 1;
                @(negedge clk); send = 0;
                repeat (5) @(negedge clk);
                check("done_send_busy", busy, 0);
                check("done_send_clk_oe", ps2clk_oe, 0);
            end
        end
        repeat (20) @(negedge clk);
        if (!aborted) check("frame", got, fr);
        check("done_n", done_cnt - d0, (aborted || nack) ? 0 : 1);
        check("err_n", err_cnt - e0, (!aborted && nack) ? 1 : 0);
    endtask
    initial begin
        int t, e0;
        repeat (5) @(negedge clk);
        check("rst_oe", {ps2clk_oe, ps2data_oe}, 0);
        check("rst_flags", {busy, done, error}, 0);
        reset = 1;
        repeat (5) @(negedge clk);
        xfer(CMD_SET_LEDS, 0, 0);
        half = 200;
        xfer(8'h01, 0, 0);
        xfer(8'h00, 0, 0);
        xfer(CMD_RESET, 0, 0);
        xfer(8'($urandom), 1, 0);
        xfer(CMD_SET_LEDS, 0, 1);
        xfer(CMD_SET_LEDS, 0, 2);
        xfer(CMD_RESET, 0, 0);
        for (int k = 0; k < 2; k++) begin
            half = $urandom_range(200, 230);
            xfer(8'($urandom), 0, 0);
        end
        start(CMD_ECHO);
        e0 = err_cnt;
        t = 0;
        while (!error && t < TO + 100) begin @(negedge clk); t++; end
        check("timeout_cycles", t, TO);
        check("timeout_data_oe", ps2data_oe, 0);
        repeat (5) @(negedge clk);
        check("timeout_err_n", err_cnt - e0, 1);
        check("timeout_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
